// File: rtl/mem_access_unit.sv
// Data-memory access stage: drives a single-port 256K x 8 RAM with programmable
// read/write latency and holds read data in MDR. Optional counters: ACCESS_CNT_EN.
module mem_access_unit #(
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic        in_Clock,
  input  logic        reset,
  input  logic [17:0] MDAR,
  input  logic [7:0]  d_in,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mdr_load,
  input  logic [7:0]  ram_rdata,
  output logic [17:0] ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_en,
  output logic        ram_we,
  output logic [7:0]  MDR,
  output logic        busy,
  output logic        done,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
  output logic [1:0]  state_dbg
);

  // Handshake: mem_read/mem_write/mdr_load are sampled only while busy=0
  // (the done cycle included); busy rises the edge after acceptance and done
  // pulses for one cycle after the completing edge. Nothing is queued.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  localparam logic [3:0] RD_INIT = 4'(RD_LAT - 1);
  localparam logic [3:0] WR_INIT = 4'(WR_LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  mdr_q, mdr_d;
  logic [17:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        en_q, en_d;
  logic        we_q, we_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        rd_fin, wr_fin;

  always_ff @(posedge in_Clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      mdr_q   <= 8'd0;
      addr_q  <= 18'd0;
      wdata_q <= 8'd0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mdr_q   <= mdr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      en_q    <= en_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mdr_d   = mdr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    en_d    = en_q;
    we_d    = we_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rd_fin  = 1'b0;
    wr_fin  = 1'b0;
    case (state_q)
      IDLE: begin
        // Read has priority; a simultaneous write is dropped.
        if (mem_read) begin
          addr_d  = MDAR;
          en_d    = 1'b1;
          we_d    = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = RD_INIT;
          state_d = RD_WAIT;
        end else if (mem_write) begin
          addr_d  = MDAR;
          wdata_d = d_in;
          en_d    = 1'b1;
          we_d    = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = WR_INIT;
          state_d = WR_WAIT;
        end else if (mdr_load) begin
          mdr_d = d_in;
        end
      end
      RD_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          mdr_d   = ram_rdata;
          en_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          rd_fin  = 1'b1;
          state_d = IDLE;
        end
      end
      WR_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          en_d    = 1'b0;
          we_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          wr_fin  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        en_d    = 1'b0;
        we_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

`ifdef ACCESS_CNT_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;

  always_ff @(posedge in_Clock or posedge reset) begin
    if (reset) begin
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Counters wrap naturally at 16 bits.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (rd_fin) rd_cnt_d = rd_cnt_q + 16'd1;
    if (wr_fin) wr_cnt_d = wr_cnt_q + 16'd1;
  end

  always_comb begin
    rd_count = rd_cnt_q;
    wr_count = wr_cnt_q;
  end
`else
  always_comb begin
    rd_count = 16'd0;
    wr_count = 16'd0;
  end
`endif

  always_comb begin
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    ram_en    = en_q;
    ram_we    = we_q;
    MDR       = mdr_q;
    busy      = busy_q;
    done      = done_q;
    state_dbg = state_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a 1-cycle registered RAM model.
// Counter checks follow ACCESS_CNT_EN.
module tb_mem_access_unit;

  logic        in_Clock = 1'b0;
  logic        reset;
  logic [17:0] MDAR;
  logic [7:0]  d_in;
  logic        mem_read, mem_write, mdr_load;
  logic [7:0]  ram_rdata = 8'd0;
  logic [17:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_en, ram_we;
  logic [7:0]  MDR;
  logic        busy, done;
  logic [15:0] rd_count, wr_count;
  logic [1:0]  state_dbg;

  logic [7:0]  mem [0:262143];
  logic [7:0]  exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  mem_access_unit #(.RD_LAT(2), .WR_LAT(1)) dut (
    .in_Clock (in_Clock),
    .reset    (reset),
    .MDAR     (MDAR),
    .d_in     (d_in),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mdr_load (mdr_load),
    .ram_rdata(ram_rdata),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .MDR      (MDR),
    .busy     (busy),
    .done     (done),
    .rd_count (rd_count),
    .wr_count (wr_count),
    .state_dbg(state_dbg)
  );

  // Clock / reset
  always #5 in_Clock = ~in_Clock;

  // RAM model: synchronous write, one-cycle registered read.
  always @(posedge in_Clock) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic tick();
    @(negedge in_Clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_mdr(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s: observed empty expected-queue expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {24'd0, MDR}, {24'd0, e});
    end
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) mem[i] = 8'h00;
    mem[18'h2ABCD] = 8'h5A;
    reset = 1'b1; MDAR = 18'd0; d_in = 8'd0;
    mem_read = 1'b0; mem_write = 1'b0; mdr_load = 1'b0;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    chk("rst_mdr",   {24'd0, MDR}, 32'd0);
    chk("rst_en",    {31'd0, ram_en}, 32'd0);
    chk("rst_we",    {31'd0, ram_we}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_addr",  {14'd0, ram_addr}, 32'd0);
    chk("rst_state", {30'd0, state_dbg}, 32'd0);
    chk("rst_rdcnt", {16'd0, rd_count}, 32'd0);

    // Read 0x2ABCD, RD_LAT=2
    MDAR = 18'h2ABCD; mem_read = 1'b1; exp_q.push_back(8'h5A);
    tick(); mem_read = 1'b0; MDAR = 18'h00001;
    chk("rd_addr",  {14'd0, ram_addr}, 32'h2ABCD);
    chk("rd_en",    {31'd0, ram_en}, 32'd1);
    chk("rd_busy",  {31'd0, busy}, 32'd1);
    chk("rd_state", {30'd0, state_dbg}, 32'd1);
    tick();
    chk("rd_mid_done", {31'd0, done}, 32'd0);
    chk("rd_mid_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("rd_done", {31'd0, done}, 32'd1);
    chk("rd_busy_clr", {31'd0, busy}, 32'd0);
    chk("rd_en_clr", {31'd0, ram_en}, 32'd0);
    chk_mdr("rd_mdr");
    tick();
    chk("rd_done_pulse", {31'd0, done}, 32'd0);

    // Write 0xC3 to 0x10, WR_LAT=1
    MDAR = 18'h00010; d_in = 8'hC3; mem_write = 1'b1;
    tick(); mem_write = 1'b0; MDAR = 18'h3FFFF; d_in = 8'hFF;
    chk("wr_we",    {31'd0, ram_we}, 32'd1);
    chk("wr_wdata", {24'd0, ram_wdata}, 32'hC3);
    chk("wr_addr",  {14'd0, ram_addr}, 32'h10);
    chk("wr_state", {30'd0, state_dbg}, 32'd2);
    tick();
    chk("wr_we_drop", {31'd0, ram_we}, 32'd0);
    chk("wr_done",    {31'd0, done}, 32'd1);
    chk("wr_wdata_hold", {24'd0, ram_wdata}, 32'hC3);
    chk("wr_ram", {24'd0, mem[18'h10]}, 32'hC3);
    tick();
    chk("wr_done_pulse", {31'd0, done}, 32'd0);

    // Read back 0x10
    MDAR = 18'h00010; mem_read = 1'b1; exp_q.push_back(8'hC3);
    tick(); mem_read = 1'b0;
    tick(); tick();
    chk("rb_done", {31'd0, done}, 32'd1);
    chk_mdr("rb_mdr");
    tick();

    // Read+write together: read wins; re-pulse while busy ignored
    MDAR = 18'h2ABCD; d_in = 8'hEE; mem_read = 1'b1; mem_write = 1'b1;
    exp_q.push_back(8'h5A);
    tick(); mem_write = 1'b0; MDAR = 18'h00010;
    chk("rw_we", {31'd0, ram_we}, 32'd0);
    chk("rw_state", {30'd0, state_dbg}, 32'd1);
    tick(); mem_read = 1'b0;
    chk("rw_addr_hold", {14'd0, ram_addr}, 32'h2ABCD);
    chk("rw_we2", {31'd0, ram_we}, 32'd0);
    tick();
    chk("rw_done", {31'd0, done}, 32'd1);
    chk_mdr("rw_mdr");
    tick();
    chk("rw_single_done", {31'd0, done}, 32'd0);
    chk("rw_idle", {31'd0, busy}, 32'd0);
    chk("rw_ram_untouched", {24'd0, mem[18'h2ABCD]}, 32'h5A);

    // Write then read accepted in the write's done cycle
    MDAR = 18'h00020; d_in = 8'h99; mem_write = 1'b1;
    tick(); mem_write = 1'b0;
    tick();
    chk("b2b_wr_done", {31'd0, done}, 32'd1);
    MDAR = 18'h00020; mem_read = 1'b1; exp_q.push_back(8'h99);
    tick(); mem_read = 1'b0;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    chk("b2b_en", {31'd0, ram_en}, 32'd1);
    chk("b2b_state", {30'd0, state_dbg}, 32'd1);
    tick(); tick();
    chk("b2b_rd_done", {31'd0, done}, 32'd1);
    chk_mdr("b2b_mdr");
    tick();

    // mdr_load in IDLE, then mdr_load alongside a write is ignored
    d_in = 8'h77; mdr_load = 1'b1;
    tick(); mdr_load = 1'b0;
    chk("mdr_load", {24'd0, MDR}, 32'h77);
    MDAR = 18'h00030; d_in = 8'h11; mem_write = 1'b1; mdr_load = 1'b1;
    tick(); mem_write = 1'b0; mdr_load = 1'b0;
    chk("mdr_load_ign", {24'd0, MDR}, 32'h77);
    chk("mdr_load_wr", {31'd0, ram_we}, 32'd1);
    tick(); tick();

    // Counters: 4 reads and 3 writes so far
`ifdef ACCESS_CNT_EN
    chk("rd_count", {16'd0, rd_count}, 32'd4);
    chk("wr_count", {16'd0, wr_count}, 32'd3);
    force dut.rd_cnt_q = 16'hFFFF;
    #1 release dut.rd_cnt_q;
    tick();
    MDAR = 18'h2ABCD; mem_read = 1'b1; exp_q.push_back(8'h5A);
    tick(); mem_read = 1'b0;
    tick(); tick();
    chk_mdr("wrap_mdr");
    chk("rd_count_wrap", {16'd0, rd_count}, 32'd0);
    tick();
`else
    chk("rd_count_off", {16'd0, rd_count}, 32'd0);
    chk("wr_count_off", {16'd0, wr_count}, 32'd0);
`endif

    // Asynchronous reset mid-access
    MDAR = 18'h00020; mem_read = 1'b1;
    tick(); mem_read = 1'b0;
    chk("ar_busy_pre", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("ar_en",    {31'd0, ram_en}, 32'd0);
    chk("ar_we",    {31'd0, ram_we}, 32'd0);
    chk("ar_busy",  {31'd0, busy}, 32'd0);
    chk("ar_mdr",   {24'd0, MDR}, 32'd0);
    chk("ar_addr",  {14'd0, ram_addr}, 32'd0);
    chk("ar_wdata", {24'd0, ram_wdata}, 32'd0);
    chk("ar_state", {30'd0, state_dbg}, 32'd0);
    chk("ar_rdcnt", {16'd0, rd_count}, 32'd0);
    chk("ar_wrcnt", {16'd0, wr_count}, 32'd0);
    tick(); reset = 1'b0;
    tick();
    chk("ar_no_done", {31'd0, done}, 32'd0);
    tick();
    chk("ar_no_done2", {31'd0, done}, 32'd0);
    chk("ar_idle", {30'd0, state_dbg}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
